// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add 32x32 multiplier for MUL / UMULL / SMULL.
// One multiplier bit is consumed per RUN cycle. SMULL works on operand
// magnitudes and negates the 64-bit product in FIX when the signs differ.
// Optional build macro: MUL_EARLY_TERM_EN. When it is defined, RUN ends as
// soon as no set multiplier bits remain, and a zero multiplier skips RUN.
module mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             neg,
   output logic             zero
);

   localparam int PW = 2 * WIDTH;

   localparam logic [2:0] OP_MUL   = 3'b100;
   localparam logic [2:0] OP_UMULL = 3'b101;
   localparam logic [2:0] OP_SMULL = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [2:0]       r_op;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplr;
   logic             r_sign;
   logic [PW-1:0]    r_acc;
   logic [5:0]       r_cnt;
   logic [WIDTH-1:0] r_result_lo;
   logic [WIDTH-1:0] r_result_hi;
   logic             r_neg;
   logic             r_zero;

   logic             w_legal;
   logic             w_accept;
   logic             w_is_smull;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_mplr_shift;
   logic [PW-1:0]    w_acc_add;
   logic [PW-1:0]    w_fixed;
   logic             w_last;
   logic             w_skip_run;

   // Operation decode and operand magnitudes (|-2^31| stays 0x80000000 as unsigned)
   assign w_legal      = (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
   assign w_accept     = start && w_legal && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_is_smull   = (op == OP_SMULL);
   assign w_a_mag      = (w_is_smull && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign w_b_mag      = (w_is_smull && b[WIDTH-1]) ? (~b + 1'b1) : b;
   assign w_mplr_shift = r_mplr >> 1;
   assign w_acc_add    = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
   assign w_fixed      = r_sign ? (~r_acc + 1'b1) : r_acc;

`ifdef MUL_EARLY_TERM_EN
   assign w_last     = (r_cnt == 6'(WIDTH - 1)) || (w_mplr_shift == '0);
   assign w_skip_run = (w_b_mag == '0);
`else
   assign w_last     = (r_cnt == 6'(WIDTH - 1));
   assign w_skip_run = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a new start is only taken from IDLE or DONE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_state_next = w_skip_run ? S_FIX : S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            w_state_next = S_DONE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: operand load, shift-add iteration, sign fix and result capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op        <= 3'b000;
         r_mcand     <= '0;
         r_mplr      <= '0;
         r_sign      <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= 6'd0;
         r_result_lo <= '0;
         r_result_hi <= '0;
         r_neg       <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_accept) begin
         r_op    <= op;
         r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
         r_mplr  <= w_b_mag;
         r_sign  <= w_is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_acc   <= '0;
         r_cnt   <= 6'd0;
      end else if (r_state == S_RUN) begin
         r_acc   <= w_acc_add;
         r_mcand <= r_mcand << 1;
         r_mplr  <= w_mplr_shift;
         r_cnt   <= r_cnt + 6'd1;
      end else if (r_state == S_FIX) begin
         r_result_lo <= w_fixed[WIDTH-1:0];
         if (r_op == OP_MUL) begin
            r_result_hi <= '0;
            r_neg       <= w_fixed[WIDTH-1];
            r_zero      <= (w_fixed[WIDTH-1:0] == '0);
         end else begin
            r_result_hi <= w_fixed[PW-1:WIDTH];
            r_neg       <= w_fixed[PW-1];
            r_zero      <= (w_fixed == '0);
         end
      end
   end

   // Outputs come only from registers
   assign busy      = (r_state == S_RUN) || (r_state == S_FIX);
   assign done      = (r_state == S_DONE);
   assign result_lo = r_result_lo;
   assign result_hi = r_result_hi;
   assign neg       = r_neg;
   assign zero      = r_zero;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed bench for mul_unit with a result scoreboard.
// Expected products come from a behavioural 64-bit multiply; the expected
// done cycle is counted from the edge that samples start (edge 0).
module tb_mul_unit;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        n;
      logic        z;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] result_lo;
   logic [31:0] result_hi;
   logic        neg;
   logic        zero;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   mul_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .neg       (neg),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Behavioural reference product
   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] p;
      if (o == 3'b110) begin
         p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      end else begin
         p = {32'h0, x} * {32'h0, y};
      end
      e.lo = p[31:0];
      if (o == 3'b100) begin
         e.hi = 32'h0;
         e.n  = p[31];
         e.z  = (p[31:0] == 32'h0);
      end else begin
         e.hi = p[63:32];
         e.n  = p[63];
         e.z  = (p == 64'h0);
      end
      e.cyc = 0;
      return e;
   endfunction

   // Cycle (relative to the start edge) in which done is expected
   function automatic int done_cycle(input logic [2:0] o, input logic [31:0] y);
`ifdef MUL_EARLY_TERM_EN
      logic [31:0] m;
      int          top;
      m   = (o == 3'b110 && y[31]) ? (~y + 32'd1) : y;
      top = -1;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) top = i;
      end
      return top + 1 + 2;
`else
      return 34;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one start; restart=1 makes the sampling edge cycle 0
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit restart);
      exp_t e;
      if (restart) cyc = 0;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      if (o == 3'b100 || o == 3'b101 || o == 3'b110) begin
         e     = model(o, x, y);
         e.cyc = cyc + done_cycle(o, y);
         sb.push_back(e);
      end
      step();
      start = 1'b0;
   endtask

   // Wait (bounded) for done, then pop and compare one scoreboard entry
   task automatic wait_done(input string tag);
      exp_t e;
      int   guard;
      guard = 0;
      while (done !== 1'b1 && guard < 300) begin
         step();
         guard++;
      end
      chk({tag, "_done_seen"}, 64'(done), 64'd1);
      chk({tag, "_sb_entry"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         $display("txn %s: cyc=%0d lo=%h hi=%h n=%b z=%b", tag, cyc, result_lo, result_hi, neg, zero);
         chk({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
         chk({tag, "_lo"}, 64'(result_lo), 64'(e.lo));
         chk({tag, "_hi"}, 64'(result_hi), 64'(e.hi));
         chk({tag, "_neg"}, 64'(neg), 64'(e.n));
         chk({tag, "_zero"}, 64'(zero), 64'(e.z));
      end
   endtask

   initial begin
      // Reset state
      reset = 1'b0;
      repeat (3) step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_lo", 64'(result_lo), 64'd0);
      chk("rst_hi", 64'(result_hi), 64'd0);
      chk("rst_neg", 64'(neg), 64'd0);
      chk("rst_zero", 64'(zero), 64'd0);
      reset = 1'b1;
      step();

      // UMULL max * max
      issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("umull_busy_c1", 64'(busy), 64'd1);
      wait_done("umull_max");
      chk("umull_max_lo_lit", 64'(result_lo), 64'h0000_0001);
      chk("umull_max_hi_lit", 64'(result_hi), 64'hFFFF_FFFE);
      step();
      chk("umull_done_pulse", 64'(done), 64'd0);
      chk("umull_busy_after", 64'(busy), 64'd0);

      // Illegal op: no start, results untouched
      issue(3'b111, 32'h1234_5678, 32'h0000_0002, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("illegal_busy", 64'(busy), 64'd0);
         step();
      end
      chk("illegal_done", 64'(done), 64'd0);
      chk("illegal_lo_hold", 64'(result_lo), 64'h0000_0001);
      chk("illegal_hi_hold", 64'(result_hi), 64'hFFFF_FFFE);
      chk("illegal_neg_hold", 64'(neg), 64'd1);
      $display("txn illegal_op: busy=%b lo=%h", busy, result_lo);

      // SMULL sign cases
      issue(3'b110, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
      wait_done("smull_m1x5");
      step();
      issue(3'b110, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done("smull_min_sq");
      chk("smull_min_sq_hi_lit", 64'(result_hi), 64'h4000_0000);
      step();
      issue(3'b110, 32'h0000_1234, 32'hFFFF_0000, 1'b1);
      wait_done("smull_pos_neg");
      step();

      // MUL truncation to zero
      issue(3'b100, 32'h0001_0000, 32'h0001_0000, 1'b1);
      wait_done("mul_zero");
      chk("mul_zero_lit", 64'(zero), 64'd1);
      step();
      issue(3'b100, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
      wait_done("mul_neg");
      step();

      // Start while busy is ignored; then back-to-back issue from DONE
      issue(3'b101, 32'h0000_0002, 32'h0000_0003, 1'b1);
`ifndef MUL_EARLY_TERM_EN
      while (cyc < 10) step();
      op    = 3'b101;
      a     = 32'h0000_0064;
      b     = 32'h0000_0064;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ignored_busy", 64'(busy), 64'd1);
`endif
      wait_done("umull_2x3");
      issue(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done("umull_b2b");
      step();

      // Reset mid-operation aborts with no done
      issue(3'b110, 32'hFFFF_FF00, 32'h8123_4567, 1'b1);
      while (cyc < 15) step();
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_lo", 64'(result_lo), 64'd0);
      chk("abort_hi", 64'(result_hi), 64'd0);
      chk("abort_neg", 64'(neg), 64'd0);
      chk("abort_zero", 64'(zero), 64'd0);
      sb.delete();
      for (int i = 0; i < 2; i++) begin
         step();
         chk("abort_no_done", 64'(done), 64'd0);
      end
      reset = 1'b1;
      step();
      issue(3'b101, 32'h0000_0007, 32'h0000_0003, 1'b1);
      wait_done("umull_7x3");
      chk("umull_7x3_lit", 64'(result_lo), 64'd21);
      step();

      // Zero multiplier
      issue(3'b101, 32'h0000_0005, 32'h0000_0000, 1'b1);
      wait_done("umull_bzero");
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
